noekeon_round_ctrl: RTL and testbench

Control FSM that sequences the Noekeon datapath: the 128-bit data register, the round-function block and the working-key register. Accepts one block per request over a valid/ready handshake and selects which source the data register loads (key, external, round output). Generates the round constants and runs 16 rounds plus the final theta. Holds the result until the consumer acknowledges it.

---
 rtl/noekeon_round_ctrl.sv | 173 +++++++++++++++++
 tb/tb_noekeon_round_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/noekeon_round_ctrl.sv
// rtl/noekeon_round_ctrl.sv - Noekeon round sequencer: source select, round constants, result hold.
// Define NOEKEON_INDIRECT_KEY_EN to build the working key (null-key encryption) per request.
module noekeon_round_ctrl (
    input  logic       inClk,
    input  logic       inResetN,
    input  logic       inValid,
    input  logic       inDecrypt,
    output logic       outReady,
    output logic       outValid,
    input  logic       inAck,
    output logic       outDataWrKey,
    output logic       outDataWrExt,
    output logic       outDataWrInt,
    output logic       outKeyWrInt,
    output logic       outKeyNull,
    output logic       outFinal,
    output logic       outDecrypt,
    output logic [7:0] outRc1,
    output logic [7:0] outRc2,
    output logic [3:0] outRound
);

    localparam logic [2:0] IDLE  = 3'd0;
`ifdef NOEKEON_INDIRECT_KEY_EN
    localparam logic [2:0] KLOAD = 3'd1;
    localparam logic [2:0] KRUN  = 3'd2;
    localparam logic [2:0] KFIN  = 3'd3;
`endif
    localparam logic [2:0] LOAD  = 3'd4;
    localparam logic [2:0] RUN   = 3'd5;
    localparam logic [2:0] FIN   = 3'd6;
    localparam logic [2:0] DONE  = 3'd7;

    localparam logic [7:0] RC_FIRST = 8'h80;
    localparam logic [7:0] RC_LAST  = 8'hD4;

    logic [2:0] state;
    logic [7:0] rc;
    logic [3:0] round;
    logic       decrypt;

    function automatic logic [7:0] rcForward(input logic [7:0] c);
        return {c[6:0], 1'b0} ^ (c[7] ? 8'h1B : 8'h00);
    endfunction

    // Exact inverse of rcForward, so decryption walks the encrypt sequence backwards.
    function automatic logic [7:0] rcBackward(input logic [7:0] c);
        logic [7:0] t;
        t = c ^ 8'h1B;
        return c[0] ? {1'b1, t[7:1]} : {1'b0, c[7:1]};
    endfunction

    always_ff @(posedge inClk or negedge inResetN) begin
        if (!inResetN) begin
            state   <= IDLE;
            rc      <= 8'h00;
            round   <= 4'd0;
            decrypt <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (inValid) begin
                        decrypt <= inDecrypt;
`ifdef NOEKEON_INDIRECT_KEY_EN
                        state   <= KLOAD;
`else
                        state   <= LOAD;
`endif
                    end
                end
`ifdef NOEKEON_INDIRECT_KEY_EN
                KLOAD: begin
                    rc    <= RC_FIRST;
                    round <= 4'd0;
                    state <= KRUN;
                end
                KRUN: begin
                    rc    <= rcForward(rc);
                    round <= round + 4'd1;
                    if (round == 4'd15) state <= KFIN;
                end
                KFIN: begin
                    state <= LOAD;
                end
`endif
                LOAD: begin
                    if (inValid) begin
                        rc    <= decrypt ? RC_LAST : RC_FIRST;
                        round <= 4'd0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    rc    <= decrypt ? rcBackward(rc) : rcForward(rc);
                    round <= round + 4'd1;
                    if (round == 4'd15) state <= FIN;
                end
                FIN: begin
                    state <= DONE;
                end
                DONE: begin
                    if (inAck) begin
                        state   <= IDLE;
                        rc      <= 8'h00;
                        decrypt <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        outReady     = 1'b0;
        outValid     = 1'b0;
        outDataWrInt = 1'b0;
        outFinal     = 1'b0;
        outRc1       = 8'h00;
        outRc2       = 8'h00;
        outRound     = 4'd0;
        case (state)
`ifdef NOEKEON_INDIRECT_KEY_EN
            KRUN: begin
                outDataWrInt = 1'b1;
                outRc1       = rc;
                outRound     = round;
            end
            KFIN: begin
                outFinal = 1'b1;
                outRc1   = rc;
            end
`endif
            LOAD: begin
                outReady = 1'b1;
            end
            RUN: begin
                outDataWrInt = 1'b1;
                outRound     = round;
                if (decrypt) outRc2 = rc;
                else         outRc1 = rc;
            end
            FIN: begin
                outDataWrInt = 1'b1;
                outFinal     = 1'b1;
                if (decrypt) outRc2 = rc;
                else         outRc1 = rc;
            end
            DONE: begin
                outValid = 1'b1;
            end
            default: begin
                outReady = 1'b0;
            end
        endcase
    end

`ifdef NOEKEON_INDIRECT_KEY_EN
    assign outDataWrKey = (state == KLOAD);
    assign outKeyWrInt  = (state == KFIN);
    assign outKeyNull   = (state == KRUN) || (state == KFIN);
`else
    assign outDataWrKey = 1'b0;
    assign outKeyWrInt  = 1'b0;
    assign outKeyNull   = 1'b0;
`endif

    // The only Mealy output: the accept strobe follows inValid within the LOAD cycle.
    assign outDataWrExt = (state == LOAD) && inValid;
    assign outDecrypt   = decrypt;

endmodule

// File: tb/tb_noekeon_round_ctrl.sv
// tb/tb_noekeon_round_ctrl.sv - cycle-schedule checker for noekeon_round_ctrl (both key build modes).
module tb_noekeon_round_ctrl;

    logic       inClk;
    logic       inResetN;
    logic       inValid;
    logic       inDecrypt;
    logic       inAck;
    logic       outReady, outValid, outDataWrKey, outDataWrExt, outDataWrInt;
    logic       outKeyWrInt, outKeyNull, outFinal, outDecrypt;
    logic [7:0] outRc1, outRc2;
    logic [3:0] outRound;

    noekeon_round_ctrl dut (
        .inClk(inClk), .inResetN(inResetN), .inValid(inValid), .inDecrypt(inDecrypt),
        .outReady(outReady), .outValid(outValid), .inAck(inAck),
        .outDataWrKey(outDataWrKey), .outDataWrExt(outDataWrExt), .outDataWrInt(outDataWrInt),
        .outKeyWrInt(outKeyWrInt), .outKeyNull(outKeyNull), .outFinal(outFinal),
        .outDecrypt(outDecrypt), .outRc1(outRc1), .outRc2(outRc2), .outRound(outRound)
    );

    initial inClk = 1'b0;
    always #5 inClk = ~inClk;

    localparam int P_IDLE = 0, P_KLOAD = 1, P_KRUN = 2, P_KFIN = 3;
    localparam int P_LOAD = 4, P_RUN = 5, P_FIN = 6, P_DONE = 7;
`ifdef NOEKEON_INDIRECT_KEY_EN
    localparam int BASE_LAT = 37;
`else
    localparam int BASE_LAT = 19;
`endif

    // Published encryption constants, then the final-theta constant at index 16.
    logic [7:0] encTab [0:16] = '{8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A,
                                  8'h2F, 8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A, 8'hD4};

    int nCmp = 0;
    int nBad = 0;

    logic [28:0] obs;
    assign obs = {outReady, outValid, outDataWrKey, outDataWrExt, outDataWrInt, outKeyWrInt,
                  outKeyNull, outFinal, outDecrypt, outRc1, outRc2, outRound};

    function automatic logic [28:0] expOut(input int phase, input int k, input logic dec, input logic v);
        logic rdy, vld, wk, we, wi, kw, kn, fin, dm;
        logic [7:0] rc1, rc2;
        logic [3:0] rnd;
        {rdy, vld, wk, we, wi, kw, kn, fin} = 8'h00;
        rc1 = 8'h00; rc2 = 8'h00; rnd = 4'd0;
        dm = (phase == P_IDLE) ? 1'b0 : dec;
        case (phase)
            P_KLOAD: wk = 1'b1;
            P_KRUN:  begin wi = 1'b1; kn = 1'b1; rc1 = encTab[k]; rnd = 4'(k); end
            P_KFIN:  begin fin = 1'b1; kn = 1'b1; kw = 1'b1; rc1 = encTab[16]; end
            P_LOAD:  begin rdy = 1'b1; we = v; end
            P_RUN:   begin
                wi = 1'b1; rnd = 4'(k);
                if (dec) rc2 = encTab[16-k]; else rc1 = encTab[k];
            end
            P_FIN:   begin
                wi = 1'b1; fin = 1'b1;
                if (dec) rc2 = encTab[0]; else rc1 = encTab[16];
            end
            P_DONE:  vld = 1'b1;
            default: dm = 1'b0;
        endcase
        return {rdy, vld, wk, we, wi, kw, kn, fin, dm, rc1, rc2, rnd};
    endfunction

    task automatic check(input string nm, input logic [28:0] e, input logic [28:0] a);
        nCmp++;
        if (a !== e) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // One clock: inputs already driven; compare mid-cycle, then move to just after the next edge.
    task automatic cyc(input string nm, input int phase, input int k, input logic dec, output logic ov);
        @(negedge inClk);
        check($sformatf("%s[%0d]", nm, k), expOut(phase, k, dec, inValid), obs);
        ov = outValid;
        @(posedge inClk);
        #1;
    endtask

    task automatic runTxn(input logic dec, input int gap, input int ackDelay, input int expLat,
                          input int resetAt);
        int c;
        int seen;
        logic ov;
        c = 0;
        seen = -1;
        inValid = 1'b1; inDecrypt = dec; inAck = 1'($urandom);
        cyc("idle", P_IDLE, 0, dec, ov);
`ifdef NOEKEON_INDIRECT_KEY_EN
        inDecrypt = 1'($urandom); inAck = 1'($urandom);
        c++; cyc("kload", P_KLOAD, 0, dec, ov);
        for (int k = 0; k < 16; k++) begin
            inAck = 1'($urandom);
            c++; cyc("krun", P_KRUN, k, dec, ov);
        end
        c++; cyc("kfin", P_KFIN, 0, dec, ov);
`endif
        for (int g = 0; g < gap; g++) begin
            inValid = 1'b0; inAck = 1'($urandom);
            c++; cyc("load_wait", P_LOAD, g, dec, ov);
        end
        inValid = 1'b1; inDecrypt = 1'($urandom);
        c++; cyc("load_accept", P_LOAD, gap, dec, ov);
        for (int k = 0; k < 16; k++) begin
            if (k == resetAt) begin
                #2 inResetN = 1'b0;
                #1 check("async_reset", 29'h0, obs);
                inValid = 1'b0;
                repeat (2) @(posedge inClk);
                @(negedge inClk);
                check("reset_hold", 29'h0, obs);
                inResetN = 1'b1;
                @(posedge inClk);
                #1;
                return;
            end
            inValid = 1'($urandom); inDecrypt = 1'($urandom); inAck = 1'($urandom);
            c++; cyc("run", P_RUN, k, dec, ov);
        end
        c++; cyc("fin", P_FIN, 0, dec, ov);
        for (int d = 0; d <= ackDelay; d++) begin
            inAck = (d == ackDelay); inValid = 1'($urandom);
            c++; cyc("done", P_DONE, d, dec, ov);
            if (ov && seen < 0) seen = c;
        end
        nCmp++;
        if (seen != expLat) begin
            nBad++;
            $display("FAIL latency: got %0d expected %0d", seen, expLat);
        end
        inAck = 1'b0;
    endtask

    typedef struct {
        logic dec;
        int   gap;
        int   ackDelay;
        int   expLat;
    } vec_t;

    vec_t vecs [6];
    logic ov0;

    initial begin
        vecs[0] = '{1'b0, 0, 0, BASE_LAT};
        vecs[1] = '{1'b1, 0, 0, BASE_LAT};
        vecs[2] = '{1'b0, 3, 5, BASE_LAT + 3};
        vecs[3] = '{1'b1, 2, 1, BASE_LAT + 2};
        vecs[4] = '{1'b0, 0, 5, BASE_LAT};
        vecs[5] = '{1'b1, 1, 3, BASE_LAT + 1};

        inResetN = 1'b0; inValid = 1'b0; inDecrypt = 1'b0; inAck = 1'b0;
        #12 check("reset_state", 29'h0, obs);
        @(negedge inClk) inResetN = 1'b1;
        @(posedge inClk);
        #1;
        inAck = 1'b1;
        cyc("idle_no_req", P_IDLE, 0, 1'b0, ov0);
        inAck = 1'b0;
        cyc("idle_no_req", P_IDLE, 1, 1'b0, ov0);

        for (int i = 0; i < 6; i++)
            runTxn(vecs[i].dec, vecs[i].gap, vecs[i].ackDelay, vecs[i].expLat, -1);

        runTxn(1'b0, 0, 0, BASE_LAT, 7);
        runTxn(1'b0, 0, 2, BASE_LAT, -1);
        runTxn(1'b1, 1, 0, BASE_LAT + 1, 7);
        runTxn(1'b1, 0, 0, BASE_LAT, -1);

        for (int i = 0; i < 8; i++) begin
            int g;
            g = $urandom_range(0, 3);
            runTxn(1'($urandom), g, $urandom_range(0, 6), BASE_LAT + g, -1);
        end

        inValid = 1'b0;
        cyc("idle_after", P_IDLE, 0, 1'b0, ov0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
